// File: rtl/tt_pkg.sv
// Shared types and helpers for the time-triggered transmit scheduler.
package tt_pkg;

    localparam int unsigned TT_CH_W_MIN = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FIRING = 2'd2
    } tt_state_e;

    // Wrap-safe release check: (gtb - nxt) viewed as signed at the sign bit
    // selected by sign_mask; reached when that difference is non-negative.
    function automatic logic time_reached(input logic [63:0] gtb,
                                          input logic [63:0] nxt,
                                          input logic [63:0] sign_mask);
        logic [63:0] diff;
        diff = gtb - nxt;
        return ((diff & sign_mask) == 64'd0);
    endfunction

endpackage

// File: rtl/tt_channel.sv
// One schedule channel: release-time compare, pulse timer and periodic re-arm.
module tt_channel
    import tt_pkg::*;
#(
    parameter int TIME_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] gtb_i,
    input  logic              wr_i,
    input  logic              dis_i,
    input  logic [TIME_W-1:0] time_i,
    input  logic [TIME_W-1:0] period_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              tx_o,
    output logic              armed_o,
    output logic              miss_o
);

    localparam logic [63:0] SIGN_MASK = 64'd1 << (TIME_W - 1);

    tt_state_e         state_q, state_d;
    logic [TIME_W-1:0] next_q, next_d;
    logic [TIME_W-1:0] period_q, period_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              tx_q, tx_d;
    logic              miss_q, miss_d;

    logic [TIME_W-1:0] diff_s;
    logic              reached_s;

    assign diff_s    = gtb_i - next_q;
    assign reached_s = time_reached(64'(gtb_i), 64'(next_q), SIGN_MASK);

    // Next-state and next-output logic; disable beats write, write beats firing.
    always_comb begin
        state_d  = state_q;
        next_d   = next_q;
        period_d = period_q;
        len_d    = len_q;
        count_d  = count_q;
        tx_d     = 1'b0;
        miss_d   = 1'b0;
        if (dis_i) begin
            state_d = IDLE;
        end else if (wr_i) begin
            state_d  = ARMED;
            next_d   = time_i;
            period_d = period_i;
            len_d    = (len_i == '0) ? LEN_W'(1) : len_i;
            count_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ARMED: begin
                    if (reached_s) begin
                        state_d = FIRING;
                        tx_d    = 1'b1;
                        miss_d  = (diff_s != '0);
                        count_d = len_q - LEN_W'(1);
                        if (period_q != '0) begin
                            next_d = next_q + period_q;
                        end else begin
                            next_d = next_q;
                        end
                    end else begin
                        state_d = ARMED;
                    end
                end
                FIRING: begin
                    if (count_q == '0) begin
                        state_d = (period_q != '0) ? ARMED : IDLE;
                    end else begin
                        tx_d    = 1'b1;
                        count_d = count_q - LEN_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            next_q   <= '0;
            period_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            tx_q     <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            next_q   <= next_d;
            period_q <= period_d;
            len_q    <= len_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            miss_q   <= miss_d;
        end
    end

    assign tx_o    = tx_q;
    assign miss_o  = miss_q;
    assign armed_o = (state_q == ARMED);

endmodule

// File: rtl/tt_scheduler.sv
// Multi-channel time-triggered transmit scheduler: decodes the config port
// and replicates one tt_channel per schedule channel.
module tt_scheduler
    import tt_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int TIME_W   = 32,
    parameter  int LEN_W    = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : int'(TT_CH_W_MIN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TIME_W-1:0]   gtb,
    input  logic                cfg_wr,
    input  logic                cfg_dis,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [TIME_W-1:0]   cfg_time,
    input  logic [TIME_W-1:0]   cfg_period,
    input  logic [LEN_W-1:0]    cfg_len,
    output logic [CHANNELS-1:0] tx,
    output logic [CHANNELS-1:0] armed,
    output logic [CHANNELS-1:0] miss
);

    logic [CHANNELS-1:0] wr_s;
    logic [CHANNELS-1:0] dis_s;

    // Out-of-range channel numbers match no decoder output and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr_s[i]  = cfg_wr  && (cfg_ch == CH_W'(i));
        assign dis_s[i] = cfg_dis && (cfg_ch == CH_W'(i));

        tt_channel #(
            .TIME_W (TIME_W),
            .LEN_W  (LEN_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .gtb_i    (gtb),
            .wr_i     (wr_s[i]),
            .dis_i    (dis_s[i]),
            .time_i   (cfg_time),
            .period_i (cfg_period),
            .len_i    (cfg_len),
            .tx_o     (tx[i]),
            .armed_o  (armed[i]),
            .miss_o   (miss[i])
        );
    end

endmodule

// File: doc/tt_scheduler.md
Name: tt_scheduler

Overview:
Multi-channel time-triggered transmit scheduler. Each channel compares the global time base (gtb) against its own programmed release time and emits a tx pulse of programmable length. It supports periodic auto-rearm, wrap-aware late-match detection and deadline-miss reporting. It sits between the global time base counter and the per-channel transmit gates, and replaces single-channel equality comparators.

Parameters:
CHANNELS, 4, number of independent schedule channels (1..16)
TIME_W, 32, width of gtb and of all schedule/period values
LEN_W, 8, width of the pulse-length field

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
gtb  in  TIME_W  global time base, free-running, wraps modulo 2^TIME_W
cfg_wr  in  1  write strobe: load the channel selected by cfg_ch
cfg_dis  in  1  disable strobe: disable the channel selected by cfg_ch
cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel
cfg_time  in  TIME_W  first release time
cfg_period  in  TIME_W  repeat period; 0 = one-shot
cfg_len  in  LEN_W  tx high time in cycles; 0 is treated as 1
tx  out  CHANNELS  per-channel transmit pulse
armed  out  CHANNELS  channel waiting for its release time
miss  out  CHANNELS  one-cycle pulse: release time detected late (gtb already past it)

Behaviour:
- Reset: synchronous, active-high; clock and reset are named clk and rst. Every channel goes to IDLE; tx, armed and miss are all 0; internal next/period/len/count are 0. Reset wins over everything else, including mid-pulse.
- Per-channel FSM states: IDLE, ARMED, FIRING.
- Config write (cfg_wr=1, cfg_dis=0):
  - Loads next=cfg_time, period=cfg_period, len=max(cfg_len,1).
  - Channel enters ARMED on the next cycle from any state. An in-progress pulse is aborted, so tx drops the next cycle.
  - Channels other than cfg_ch are unaffected.
- cfg_dis=1: the channel goes to IDLE on the next cycle and tx drops. If cfg_wr and cfg_dis are both 1, disable wins.
- Out-of-range cfg_ch (non-power-of-2 CHANNELS): the write is ignored.
- Reached condition: d = gtb - next modulo 2^TIME_W, interpreted as signed; reached when d >= 0. This is wrap-safe for deadlines within 2^(TIME_W-1) cycles.
- ARMED and reached:
  - State goes to FIRING; tx goes high at the next clock edge (latency 1 cycle from the gtb sample).
  - count is loaded with len-1.
  - If d != 0, miss pulses for exactly 1 cycle, aligned with the first tx cycle.
  - If period != 0: next <= next + period (modulo, carry dropped) at the same edge.
- FIRING:
  - tx=1. count decrements each cycle.
  - When count=0: if period != 0, go to ARMED; otherwise go to IDLE. tx is therefore high for exactly len cycles.
- A release time that falls during FIRING is evaluated on return to ARMED. It fires immediately (tx low for exactly 1 cycle between pulses) with miss=1.
- One pulse per release. A release time is never skipped silently and never fires twice.
- armed = (state == ARMED). tx and miss are registered outputs with no combinational path from gtb.
- Config writes to the channel being evaluated in the same cycle take precedence over firing.

Decomposition:
- Package tt_pkg contains:
  - enum tt_state_e {IDLE, ARMED, FIRING}
  - function time_reached(gtb, next) implementing the signed-difference compare
  - localparam for the minimum cfg_ch width
- Sub-module tt_channel holds one channel's FSM, next/period/len/count registers and its tx/miss/armed outputs. It takes a decoded per-channel write/disable strobe. tt_scheduler decodes cfg_ch and instantiates CHANNELS copies via generate.

Test Plan:
- Legacy equivalence: ch0 time=5, period=0, len=1, gtb stepping from 0 -> tx[0] high for exactly the one cycle after gtb==5, miss=0, then IDLE with armed[0]=0.
- Periodic: ch1 time=100, period=50, len=3 -> tx[1] high 3 cycles after gtb=100, 150, 200…; armed[1] returns to 1 between pulses; miss stays 0.
- Wrap-around: time=0xFFFFFFFE, period=4, gtb starting at 0xFFFFFFF0 -> fires at 0xFFFFFFFE, then at 0x00000002; no false fire while gtb < next pre-wrap.
- Late/overlap: time=10, period=2, len=4 -> second release at 12 occurs during FIRING; pulse ends, tx low 1 cycle, fires again with miss=1; next advances to 14 with no skipped releases.
- Late load: write time=20 while gtb=30 -> tx and miss high the cycle after ARMED; one-shot then IDLE.
- Abort/reset: cfg_dis during a len=8 pulse -> tx low the next cycle, IDLE. Also rst asserted mid-pulse on all channels -> all outputs 0 the next cycle and no firing until rewritten.
